aes_cipher: RTL and testbench

Iterative AES block encryptor (FIPS-197) supporting AES-128/192/256, selected by parameters. It encrypts one 128-bit block per operation and performs one cipher round per clock, with a start/valid handshake. It is the encryption datapath of the AES encrypt/decrypt core and is fed by the surrounding control logic.

---
 rtl/aes_cipher.sv | 224 ++++++++++++++++++++++
 tb/tb_aes_cipher.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/aes_cipher.sv
`timescale 1ns/1ps
// aes_cipher: iterative AES-128/192/256 block encryptor, one round per clock.
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_start  start request, accepted only while o_busy is low
//   i_key    cipher key (32*nk bits, key byte 0 in the MSBs)
//   i_data   plaintext block (byte 0 in the MSBs)
//   o_data   ciphertext, held until the next completion or reset
//   o_valid  one-cycle pulse when o_data is updated
//   o_busy   high while an encryption is in progress
module aes_cipher #(
  parameter int unsigned nk = 8,
  parameter int unsigned nr = 14
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [32*nk-1:0] i_key,
  input  logic [127:0]    i_data,
  output logic [127:0]    o_data,
  output logic            o_valid,
  output logic            o_busy
);

  localparam int unsigned KW = 32 * nk;
  localparam int unsigned NW = 4 * (nr + 1);
  localparam int unsigned EW = 32 * NW;
  localparam int unsigned RW = $clog2(nr + 1);

  // Forward S-box, row-major, entry 0x00 in the MSBs.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {ST_IDLE, ST_RUN} fsm_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = 11'(8'd255 - b) << 3;
    return SBOX[base +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int unsigned i);
    case (i)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int unsigned n = 0; n < 16; n++) r[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    return r;
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int unsigned row = 0; row < 4; row++) begin
      for (int unsigned col = 0; col < 4; col++) begin
        r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Full FIPS-197 key expansion, word 0 in the MSBs of the result.
  function automatic logic [EW-1:0] expand_key(input logic [KW-1:0] k);
    logic [31:0]   w [NW];
    logic [31:0]   tmp;
    logic [EW-1:0] r;
    for (int unsigned i = 0; i < nk; i++) w[i] = k[KW-1-32*i -: 32];
    for (int unsigned i = nk; i < NW; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon(i / nk), 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int unsigned i = 0; i < NW; i++) r[EW-1-32*i -: 32] = w[i];
    return r;
  endfunction

  fsm_e            fsm_q, fsm_d;
  logic [RW-1:0]   round_q, round_d;
  logic [127:0]    st_q, st_d;
  logic [KW-1:0]   key_q, key_d;
  logic [127:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic [EW-1:0]   sched_c;
  logic [127:0]    rk_c;
  logic [127:0]    sr_c;
  logic [127:0]    mid_c;

  assign sched_c = expand_key(key_q);

  // Round key for the round currently held in the counter.
  always_comb begin
    rk_c = '0;
    for (int unsigned r = 0; r <= nr; r++) begin
      if (round_q == RW'(r)) rk_c = sched_c[EW-1-128*r -: 128];
    end
  end

  assign sr_c  = shift_rows(sub_bytes(st_q));
  assign mid_c = mix_columns(sr_c) ^ rk_c;

  // Next-state and datapath control.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    st_d    = st_q;
    key_d   = key_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (fsm_q)
      ST_IDLE: begin
        if (i_start) begin
          key_d   = i_key;
          st_d    = i_data ^ i_key[KW-1 -: 128];
          round_d = RW'(1);
          busy_d  = 1'b1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (round_q == RW'(nr)) begin
          data_d  = sr_c ^ rk_c;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          round_d = '0;
          fsm_d   = ST_IDLE;
        end else begin
          st_d    = mid_c;
          round_d = round_q + RW'(1);
        end
      end
      default: begin
        fsm_d   = ST_IDLE;
        busy_d  = 1'b0;
        round_d = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q   <= ST_IDLE;
      round_q <= '0;
      st_q    <= '0;
      key_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      st_q    <= st_d;
      key_q   <= key_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_aes_cipher.sv
`timescale 1ns/1ps
// Bench for aes_cipher: three instances (AES-256/128/192) checked against
// FIPS-197 vectors through a per-instance expected-result queue.
module tb_aes_cipher;

  localparam logic [255:0] K8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K6  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K4A = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K4B = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] DA  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] DB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] E8  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] E4A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] E4B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] E6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  typedef struct {
    logic [127:0] exp;
    int           due;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start [3];
  logic [255:0] key   [3];
  logic [127:0] din   [3];
  logic [127:0] odata [3];
  logic         ovalid[3];
  logic         obusy [3];

  sb_t sbq [3][$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_cipher #(.nk(8), .nr(14)) u_aes256 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_key(key[0]),
    .i_data(din[0]), .o_data(odata[0]), .o_valid(ovalid[0]), .o_busy(obusy[0]));

  aes_cipher #(.nk(4), .nr(10)) u_aes128 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_key(key[1][127:0]),
    .i_data(din[1]), .o_data(odata[1]), .o_valid(ovalid[1]), .o_busy(obusy[1]));

  aes_cipher #(.nk(6), .nr(12)) u_aes192 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_key(key[2][191:0]),
    .i_data(din[2]), .o_data(odata[2]), .o_valid(ovalid[2]), .o_busy(obusy[2]));

  function automatic int nr_of(input int k);
    return (k == 0) ? 14 : (k == 1) ? 10 : 12;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Called on a falling edge; start is seen by the DUT at the next rising edge.
  task automatic start_op(input int k, input logic [255:0] kv, input logic [127:0] dv,
                          input logic [127:0] exp, input bit push);
    sb_t e;
    key[k]   = kv;
    din[k]   = dv;
    start[k] = 1'b1;
    if (push) begin
      e.exp = exp;
      e.due = cyc + 1 + nr_of(k);
      sbq[k].push_back(e);
    end
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("drain%0d", k), 128'(sbq[k].size()), 128'd0);
      check_eq($sformatf("idle_busy%0d", k), 128'(obusy[k]), 128'd0);
    end
  endtask

  // Output monitor: every o_valid must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (ovalid[k]) begin
          check_eq($sformatf("expected_pending%0d", k), 128'(sbq[k].size() != 0), 128'd1);
          if (sbq[k].size() != 0) begin
            sb_t e;
            e = sbq[k].pop_front();
            check_eq($sformatf("data%0d", k), odata[k], e.exp);
            check_eq($sformatf("latency%0d", k), 128'(cyc), 128'(e.due));
            check_eq($sformatf("busy_at_valid%0d", k), 128'(obusy[k]), 128'd0);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      key[k]   = '0;
      din[k]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_data%0d", k), odata[k], 128'd0);
      check_eq($sformatf("rst_valid%0d", k), 128'(ovalid[k]), 128'd0);
      check_eq($sformatf("rst_busy%0d", k), 128'(obusy[k]), 128'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vectors on all three key sizes.
    start_op(0, K8, DA, E8, 1'b1);
    check_eq("busy_after_start0", 128'(obusy[0]), 128'd1);
    start_op(2, K6, DA, E6, 1'b1);
    start_op(1, K4A, DA, E4A, 1'b1);
    drain();
    start_op(1, K4B, DB, E4B, 1'b1);
    drain();

    // Start while busy is ignored; inputs changing after the start edge are ignored.
    start_op(1, K4A, DA, E4A, 1'b1);
    repeat (3) @(negedge clk);
    start_op(1, K4B, DB, '0, 1'b0);
    key[1] = {8{32'hdeadbeef}};
    din[1] = {4{32'hcafef00d}};
    start_op(0, K8, DA, E8, 1'b1);
    repeat (4) @(negedge clk);
    start_op(0, K4B, DB, '0, 1'b0);
    key[0] = {8{32'h5a5a1234}};
    din[0] = '1;
    drain();

    // Back-to-back: new start in the o_valid cycle.
    start_op(1, K4B, DB, E4B, 1'b1);
    for (int i = 0; i < 40 && !ovalid[1]; i++) @(negedge clk);
    check_eq("b2b_valid_seen", 128'(ovalid[1]), 128'd1);
    start_op(1, K4A, DA, E4A, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("b2b_hold", odata[1], E4B);
    check_eq("b2b_busy", 128'(obusy[1]), 128'd1);
    drain();

    // Reset in the middle of an operation.
    start_op(0, K8, DA, E8, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_data", odata[0], 128'd0);
    check_eq("midrst_valid", 128'(ovalid[0]), 128'd0);
    check_eq("midrst_busy", 128'(obusy[0]), 128'd0);
    sbq[0].delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("post_rst_data", odata[0], 128'd0);
    check_eq("post_rst_busy", 128'(obusy[0]), 128'd0);
    start_op(0, K8, DA, E8, 1'b1);
    drain();
    check_eq("final_hold", odata[0], E8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
